wb_ram_burst: RTL and testbench
===============================

# wb_ram_burst

Parametrised Wishbone B4 on-chip RAM slave for the SoC interconnect. Supports single classic accesses and registered-feedback incrementing bursts (linear and wrap-4/8/16), so a cache line or DMA transfer moves one word per clock instead of one every two. Data width and depth are configurable, with per-byte write enables. Accesses outside the memory return a bus error.

## Interface
- DATA_WIDTH, 32: word width in bits; only 32 or 64 are legal.
- MEM_WORDS, 256: depth in words; any value ≥ 16, not necessarily a power of two.
- ADDR_WIDTH, 32: width of wb_adr_i (byte address).

- wb_clk_i  in  1  single clock; all logic on its rising edge.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- wb_adr_i  in  ADDR_WIDTH  byte address; word index = wb_adr_i[ADDR_WIDTH-1:LSB], LSB = log2(DATA_WIDTH/8).
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_dat_o  out  DATA_WIDTH  read data.
- wb_sel_i  in  DATA_WIDTH/8  byte enables.
- wb_we_i  in  1  write strobe.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  beat strobe.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- wb_ack_o  out  1  beat acknowledge.
- wb_err_o  out  1  beat error (out of range).

## Operation
- Memory is an inferred array of MEM_WORDS × DATA_WIDTH with synchronous read and byte-lane writes. Contents are not reset.
- Internal registers: state (IDLE, CLASSIC, BURST), word address register `addr`, burst type `bte`, and `oor` (addr ≥ MEM_WORDS).
- IDLE: on an edge with cyc & stb:
  - load `addr` from wb_adr_i;
  - read mem[wb_adr_i index] into wb_dat_o;
  - go to BURST if cti = 010, else CLASSIC;
  - assert ack (or err if out of range) for the next cycle.
- CLASSIC: the beat completes on the next edge with stb & ack.
  - If we, write wb_dat_i to mem[addr] on lanes where sel = 1.
  - ack drops and state returns to IDLE. Each classic access therefore occupies 2 cycles.
- BURST: on each edge with stb & (ack | err):
  - write as in CLASSIC when we & ack;
  - if cti = 111, drop ack and go to IDLE;
  - otherwise advance `addr` per `bte`, read mem[next addr] into wb_dat_o, and keep ack (or err if next addr is out of range) high.
- Address advance:
  - linear: addr + 1;
  - wrap-N: low log2(N) bits increment modulo N, upper bits are held.
- Out of range: wb_err_o replaces wb_ack_o for that beat. No write occurs, wb_dat_o = 0, and on that edge state returns to IDLE, ending the burst.
- stb low during BURST (master wait state): ack/err are cleared, state returns to IDLE, and the master must restart the burst.
- cyc low in any state: the next edge forces IDLE with ack/err = 0, and no write occurs.
- wb_ack_o and wb_err_o are never high together.

## Timing
- Reset (wb_rst_ni = 0, asynchronous): state = IDLE, wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0, addr = 0. This applies even mid-burst; a write beat not yet acked is not performed. Memory contents are retained.
- Latency: first ack is 1 cycle after stb is sampled. Burst beats follow back-to-back with ack held continuously.
- Burst of N beats: N+1 cycles from first stb sample to the last ack-low.
- Classic throughput: 1 word per 2 cycles. Burst throughput: 1 word per cycle.
- Read data is valid in every cycle where ack is high. Write data is sampled on the edge that ends the ack cycle.
- The first beat takes its cti/bte from the IDLE sample. bte is ignored after the first beat; cti is examined on every beat.

## Test plan
- Classic write then read (DATA_WIDTH = 32):
  - write 0xDEADBEEF to byte address 0x10, sel = 1111, then read 0x10 → ack 1 cycle after each stb, read data 0xDEADBEEF, ack low between accesses;
  - write 0x000000AA with sel = 0001 to 0x10, then read → 0xDEADBEAA.
- Linear burst: write 8 beats, values 0..7, from address 0x40 with cti 010 ×7 then 111 → ack high for 8 consecutive cycles. A read burst from 0x40 returns 0..7 back-to-back and ack falls after the 8th beat.
- Wrap-4 read burst starting at word 6 (address 0x18), bte = 01, 4 beats → words 6, 7, 4, 5.
- Out of range, MEM_WORDS = 256:
  - classic read of word 256 → err for one cycle, no ack, data 0;
  - linear burst starting at word 254 → ack for words 254 and 255, then err on the third beat and the burst terminates;
  - memory is unchanged.
- Reset mid-burst: assert wb_rst_ni = 0 during beat 3 of a write burst → ack and err drop immediately. After release, reads show beats 1–2 written and beat 3 and later unwritten.
- Interruptions: stb dropped for 1 cycle mid-burst → ack low the next cycle and state IDLE. A restart at the next address completes normally. cyc dropped mid-burst → no further writes.

Source files
------------

// File: rtl/wb_ram_burst.sv
// Wishbone B4 on-chip RAM slave with classic cycles and registered-feedback linear/wrap bursts.
// Latency: ack/err one cycle after stb is sampled; burst beats then complete back-to-back, one per clock.
// Backpressure: none from the slave; a master wait state (stb low) or cyc low ends the burst and returns to idle.
module wb_ram_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i,
    output logic [DATA_WIDTH-1:0]     wb_dat_o,
    input  logic [DATA_WIDTH/8-1:0]   wb_sel_i,
    input  logic                      wb_we_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic [2:0]                wb_cti_i,
    input  logic [1:0]                wb_bte_i,
    output logic                      wb_ack_o,
    output logic                      wb_err_o
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int AW  = ADDR_WIDTH - LSB;
    localparam int MIW = $clog2(MEM_WORDS);

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_END  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLASSIC,
        S_BURST
    } state_t;

    state_t            state;
    logic [AW-1:0]     addr;
    logic [1:0]        bte;
    logic              oor;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [AW-1:0]     adr_word;
    logic              adr_oor;
    logic [AW-1:0]     next_addr;
    logic              next_oor;
    logic              mem_we;
    logic              unused_adr_lsb;

    // Byte offset bits carry no meaning for a word-wide RAM.
    assign unused_adr_lsb = ^wb_adr_i[LSB-1:0];

    assign adr_word = wb_adr_i[ADDR_WIDTH-1:LSB];
    assign adr_oor  = adr_word >= AW'(MEM_WORDS);
    assign next_oor = next_addr >= AW'(MEM_WORDS);

    // A beat writes only while the bus is live and it is being acked for an in-range word.
    assign mem_we = wb_cyc_i && wb_stb_i && wb_we_i && wb_ack_o && !oor;

    // Next burst word: linear increments the whole index, wrap-N rolls only the low bits.
    always_comb begin
        next_addr = addr + 1'b1;
        case (bte)
            2'b01:   next_addr = {addr[AW-1:2], addr[1:0] + 2'd1};
            2'b10:   next_addr = {addr[AW-1:3], addr[2:0] + 3'd1};
            2'b11:   next_addr = {addr[AW-1:4], addr[3:0] + 4'd1};
            default: next_addr = addr + 1'b1;
        endcase
    end

    // Bus FSM with registered ack/err and read data; memory is read one word ahead of each beat.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state    <= S_IDLE;
            addr     <= '0;
            bte      <= 2'b00;
            oor      <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else if (!wb_cyc_i) begin
            state    <= S_IDLE;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wb_stb_i) begin
                        addr     <= adr_word;
                        oor      <= adr_oor;
                        bte      <= wb_bte_i;
                        wb_ack_o <= !adr_oor;
                        wb_err_o <= adr_oor;
                        wb_dat_o <= adr_oor ? '0 : mem[adr_word[MIW-1:0]];
                        state    <= (wb_cti_i == CTI_INCR) ? S_BURST : S_CLASSIC;
                    end
                end
                S_CLASSIC: begin
                    state    <= S_IDLE;
                    wb_ack_o <= 1'b0;
                    wb_err_o <= 1'b0;
                end
                S_BURST: begin
                    if (wb_stb_i && wb_ack_o && wb_cti_i != CTI_END) begin
                        addr     <= next_addr;
                        oor      <= next_oor;
                        wb_ack_o <= !next_oor;
                        wb_err_o <= next_oor;
                        wb_dat_o <= next_oor ? '0 : mem[next_addr[MIW-1:0]];
                    end else begin
                        // Last beat, error beat or master wait state: the burst is over.
                        state    <= S_IDLE;
                        wb_ack_o <= 1'b0;
                        wb_err_o <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    wb_ack_o <= 1'b0;
                    wb_err_o <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane writes into the RAM array; contents survive reset.
    always_ff @(posedge wb_clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (wb_sel_i[b]) begin
                    mem[addr[MIW-1:0]][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_ram_burst.sv
module tb_wb_ram_burst;
    localparam int MEM_WORDS = 256;

    logic        wb_clk_i;
    logic        wb_rst_ni;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic        wb_ack_o;
    logic        wb_err_o;

    typedef struct {
        bit          err;
        bit          chk;
        logic [31:0] dat;
        int          adr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        me;
    logic [31:0] ref_mem [MEM_WORDS];
    int          checks = 0;
    int          errors = 0;

    wb_ram_burst #(
        .DATA_WIDTH(32),
        .MEM_WORDS (MEM_WORDS),
        .ADDR_WIDTH(32)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_ni(wb_rst_ni),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_cti_i (wb_cti_i),
        .wb_bte_i (wb_bte_i),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    // Word visited by beat k: linear counts up, wrap-N stays inside the aligned N-word block.
    function automatic int beat_addr(input int start, input int bt, input int k);
        int n;
        if (bt == 0) return start + k;
        n = 2 << bt;
        return (start - (start % n)) + (((start % n) + k) % n);
    endfunction

    task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic idle_bus();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_cti_i = 3'b000;
    endtask

    task automatic drive(input bit we, input int a, input logic [31:0] d, input logic [3:0] s,
                         input logic [2:0] cti, input int bt);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = 32'(a * 4) + 32'($urandom_range(0, 3));
        wb_dat_i = d;
        wb_sel_i = s;
        wb_cti_i = cti;
        wb_bte_i = 2'(bt);
    endtask

    // One master transfer. endmode: 0 = normal end, 1 = stb wait state after the last beat, 2 = cyc drop.
    task automatic xfer(input bit we, input int start, input int bt, input int n, input bit classic,
                        input int endmode, input bit rnd, input logic [31:0] dbase, input logic [3:0] dsel);
        logic [31:0] wd[$];
        logic [3:0]  ws[$];
        int          aq[$];
        exp_t        e;
        int          a;
        int          nb;
        bit          last_err;
        bit          abort;
        logic [2:0]  ct;
        nb = 0;
        last_err = 0;
        abort = 0;
        for (int k = 0; k < n; k++) begin
            a = beat_addr(start, bt, k);
            wd.push_back(rnd ? $urandom : dbase + 32'(k));
            ws.push_back(dsel == 4'h0 ? 4'($urandom_range(0, 15)) : dsel);
            aq.push_back(a);
            e.err = (a >= MEM_WORDS);
            e.chk = !we || e.err;
            e.dat = e.err ? 32'h0 : ref_mem[a];
            e.adr = a;
            exp_q.push_back(e);
            nb++;
            if (e.err) begin
                last_err = 1;
                break;
            end
            if (we) model_write(a, wd[k], ws[k]);
        end
        for (int k = 0; k < nb; k++) begin
            if (k == 0 || !abort) begin
                ct = classic ? 3'b000 : ((endmode == 0 && k == n - 1) ? 3'b111 : 3'b010);
                if (k == 0) begin
                    drive(we, aq[0], wd[0], ws[0], ct, bt);
                    @(posedge wb_clk_i); #1;
                end
                checks++;
                if (!(wb_ack_o || wb_err_o)) begin
                    errors++;
                    $display("FAIL beat_present beat=%0d word=%0d ack=%0b err=%0b required ack or err high",
                             k, aq[k], wb_ack_o, wb_err_o);
                    abort = 1;
                end else begin
                    @(posedge wb_clk_i); #1;
                    if (k + 1 < nb) begin
                        ct = (endmode == 0 && k + 1 == n - 1) ? 3'b111 : 3'b010;
                        drive(we, aq[k+1], wd[k+1], ws[k+1], ct, bt);
                    end
                end
            end
        end
        if (abort) begin
            idle_bus();
            @(posedge wb_clk_i); #1;
            exp_q.delete();
        end else if (last_err || endmode == 0) begin
            idle_bus();
            check("end_idle ack,err", 64'({wb_ack_o, wb_err_o}), 64'h0);
        end else if (endmode == 1) begin
            wb_stb_i = 1'b0;
            @(posedge wb_clk_i); #1;
            check("stb_drop_idle ack,err", 64'({wb_ack_o, wb_err_o}), 64'h0);
            idle_bus();
        end else begin
            wb_cyc_i = 1'b0;
            wb_stb_i = 1'b1;
            wb_we_i  = 1'b1;
            wb_sel_i = 4'hF;
            repeat (3) begin
                wb_dat_i = $urandom;
                @(posedge wb_clk_i); #1;
            end
            check("cyc_drop_idle ack,err", 64'({wb_ack_o, wb_err_o}), 64'h0);
            idle_bus();
        end
    endtask

    // Scoreboard: every beat the master takes (cyc & stb & response) is matched against the queue.
    always @(negedge wb_clk_i) begin
        if (wb_rst_ni && wb_cyc_i && wb_stb_i && (wb_ack_o || wb_err_o)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat ack=%0b err=%0b dat=%h required no response",
                         wb_ack_o, wb_err_o, wb_dat_o);
            end else begin
                me = exp_q.pop_front();
                if (wb_err_o !== me.err || wb_ack_o !== !me.err || (me.chk && wb_dat_o !== me.dat)) begin
                    errors++;
                    $display("FAIL beat word=%0d ack=%0b err=%0b dat=%h required ack=%0b err=%0b dat=%h (data checked=%0b)",
                             me.adr, wb_ack_o, wb_err_o, wb_dat_o, !me.err, me.err, me.dat, me.chk);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout simulation did not complete required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd[6];
        exp_t        e;
        int          n;
        bit          cl;
        int          em;

        wb_rst_ni = 1'b0;
        wb_adr_i  = '0;
        wb_dat_i  = '0;
        wb_sel_i  = '0;
        wb_bte_i  = '0;
        idle_bus();
        #12;
        check("reset ack", 64'(wb_ack_o), 64'h0);
        check("reset err", 64'(wb_err_o), 64'h0);
        check("reset dat", 64'(wb_dat_o), 64'h0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        @(posedge wb_clk_i); #1;

        // Fill the whole RAM so every word has a known value.
        xfer(1, 0, 0, MEM_WORDS, 0, 0, 1, 32'h0, 4'hF);

        // Classic write/read and a single-lane update.
        xfer(1, 4, 0, 1, 1, 0, 0, 32'hDEADBEEF, 4'hF);
        xfer(0, 4, 0, 1, 1, 0, 0, 32'h0, 4'hF);
        xfer(1, 4, 0, 1, 1, 0, 0, 32'h000000AA, 4'h1);
        xfer(0, 4, 0, 1, 1, 0, 0, 32'h0, 4'hF);

        // Linear 8-beat burst write of 0..7 at 0x40, then read back.
        xfer(1, 16, 0, 8, 0, 0, 0, 32'h0, 4'hF);
        xfer(0, 16, 0, 8, 0, 0, 0, 32'h0, 4'hF);

        // Wrap-4 from word 6, plus wrap-8 and wrap-16 reads.
        xfer(0, 6, 1, 4, 0, 0, 0, 32'h0, 4'hF);
        xfer(0, 21, 2, 8, 0, 0, 0, 32'h0, 4'hF);
        xfer(1, 45, 3, 16, 0, 0, 1, 32'h0, 4'h0);
        xfer(0, 45, 3, 16, 0, 0, 0, 32'h0, 4'hF);

        // Out of range: classic read and write, burst running off the end.
        xfer(0, 256, 0, 1, 1, 0, 0, 32'h0, 4'hF);
        xfer(1, 300, 0, 1, 1, 0, 1, 32'h0, 4'hF);
        xfer(0, 254, 0, 4, 0, 0, 0, 32'h0, 4'hF);
        xfer(1, 254, 0, 4, 0, 0, 1, 32'h0, 4'hF);

        // Wait state mid-burst, then restart at the following word.
        xfer(0, 50, 0, 3, 0, 1, 0, 32'h0, 4'hF);
        xfer(0, 53, 0, 4, 0, 0, 0, 32'h0, 4'hF);
        xfer(1, 60, 0, 3, 0, 1, 1, 32'h0, 4'hF);
        xfer(1, 63, 0, 3, 0, 0, 1, 32'h0, 4'hF);

        // cyc dropped mid write burst: no further writes.
        xfer(1, 80, 0, 3, 0, 2, 1, 32'h0, 4'hF);
        xfer(0, 80, 0, 6, 0, 0, 0, 32'h0, 4'hF);

        // Reset during the third beat of a write burst: beats 1-2 land, the rest do not.
        for (int k = 0; k < 6; k++) rd[k] = $urandom;
        for (int k = 0; k < 2; k++) begin
            e.err = 0;
            e.chk = 0;
            e.dat = 32'h0;
            e.adr = 100 + k;
            exp_q.push_back(e);
            model_write(100 + k, rd[k], 4'hF);
        end
        drive(1, 100, rd[0], 4'hF, 3'b010, 0);
        @(posedge wb_clk_i); #1;
        @(posedge wb_clk_i); #1;
        drive(1, 101, rd[1], 4'hF, 3'b010, 0);
        @(posedge wb_clk_i); #1;
        drive(1, 102, rd[2], 4'hF, 3'b010, 0);
        check("rst_pre ack", 64'(wb_ack_o), 64'h1);
        wb_rst_ni = 1'b0;
        #1;
        check("rst_mid ack,err", 64'({wb_ack_o, wb_err_o}), 64'h0);
        check("rst_mid dat", 64'(wb_dat_o), 64'h0);
        repeat (2) @(posedge wb_clk_i);
        idle_bus();
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        @(posedge wb_clk_i); #1;
        xfer(0, 100, 0, 6, 0, 0, 0, 32'h0, 4'hF);

        // Randomised mix of reads, writes, burst types, lengths and endings.
        for (int i = 0; i < 40; i++) begin
            n  = $urandom_range(1, 20);
            cl = (n == 1) && ($urandom_range(0, 1) == 1);
            em = cl ? 0 : $urandom_range(0, 2);
            xfer(1'($urandom_range(0, 1)), $urandom_range(0, 270), $urandom_range(0, 3), n, cl, em,
                 1, 32'h0, 4'h0);
        end

        // Full readback confirms nothing was written where it should not have been.
        xfer(0, 0, 0, MEM_WORDS, 0, 0, 0, 32'h0, 4'hF);

        repeat (3) @(posedge wb_clk_i);
        check("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
